// File: rtl/fifo_sb_checker_if.sv
// Observation bundle for one synchronous FIFO: the request side the FIFO sees
// and every output it produces, as seen by a passive checker.
interface fifo_sb_checker_if #(
    parameter int FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] mon_data_in;
    logic                  mon_wr_en;
    logic                  mon_rd_en;
    logic [FIFO_WIDTH-1:0] mon_data_out;
    logic                  mon_wr_ack;
    logic                  mon_overflow;
    logic                  mon_underflow;
    logic                  mon_full;
    logic                  mon_empty;
    logic                  mon_almostfull;
    logic                  mon_almostempty;

    // The FIFO side (or whatever stands in for it) drives every signal.
    modport master (
        output mon_data_in, mon_wr_en, mon_rd_en, mon_data_out,
        output mon_wr_ack, mon_overflow, mon_underflow,
        output mon_full, mon_empty, mon_almostfull, mon_almostempty
    );

    // The checker only ever listens.
    modport slave (
        input mon_data_in, mon_wr_en, mon_rd_en, mon_data_out,
        input mon_wr_ack, mon_overflow, mon_underflow,
        input mon_full, mon_empty, mon_almostfull, mon_almostempty
    );
endinterface

// File: rtl/fifo_sb_checker.sv
// Passive scoreboard for a synchronous FIFO: a shadow model predicts every
// FIFO output and mismatches are logged as sticky bits and saturating counters.
module fifo_sb_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          chk_en,
    fifo_sb_checker_if.slave              mon,
    output logic [7:0]                    err_sticky,
    output logic                          err_pulse,
    output logic [CNT_WIDTH-1:0]          pass_cnt,
    output logic [CNT_WIDTH-1:0]          err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   model_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CW-1:0]        CNT_ZERO = '0;
    localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]        CNT_AF   = CW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0]        CNT_AE   = CW'(AE_MARGIN);
    localparam logic [CW-1:0]        CNT_STEP = CW'(1);
    localparam logic [PTR_W-1:0]     PTR_STEP = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] SAT_STEP = CNT_WIDTH'(1);

    // Handshake: a request (wr_en / rd_en) is taken in the cycle it is high at a
    // rising edge if the FIFO can serve it then (not full / not empty); there is
    // no back-pressure, refused requests only show up as overflow/underflow.

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  exp_vld;
    logic                  exp_wr_ack;
    logic                  exp_overflow;
    logic                  exp_underflow;
    logic                  exp_data_vld;
    logic [FIFO_WIDTH-1:0] exp_data;
    logic [7:0]            mis;

    always_comb begin
        wr_acc = mon.mon_wr_en && (model_count != CNT_FULL);
        rd_acc = mon.mon_rd_en && (model_count != CNT_ZERO);
    end

    // Shadow storage needs no reset: stale words are never read because the
    // occupancy count gates every pop.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= mon.mon_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            model_count   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            exp_vld       <= 1'b0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            exp_data_vld  <= 1'b0;
            exp_data      <= '0;
        end else begin
            exp_vld       <= 1'b1;
            exp_wr_ack    <= wr_acc;
            exp_overflow  <= mon.mon_wr_en && (model_count == CNT_FULL);
            exp_underflow <= mon.mon_rd_en && (model_count == CNT_ZERO);
            exp_data_vld  <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (rd_acc) begin
                exp_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_STEP;
            end
            case ({wr_acc, rd_acc})
                2'b10:   model_count <= model_count + CNT_STEP;
                2'b01:   model_count <= model_count - CNT_STEP;
                default: model_count <= model_count;
            endcase
        end
    end

    // Registered outputs are compared against what the previous edge predicted;
    // flags are compared against the occupancy in force during this cycle.
    always_comb begin
        mis = '0;
        if (exp_data_vld) begin
            mis[0] = (mon.mon_data_out != exp_data);
        end
        if (exp_vld) begin
            mis[1] = (mon.mon_wr_ack    != exp_wr_ack);
            mis[2] = (mon.mon_overflow  != exp_overflow);
            mis[3] = (mon.mon_underflow != exp_underflow);
        end
        mis[4] = (mon.mon_full        != (model_count == CNT_FULL));
        mis[5] = (mon.mon_empty       != (model_count == CNT_ZERO));
        mis[6] = (mon.mon_almostfull  != (model_count == CNT_AF));
        mis[7] = (mon.mon_almostempty != (model_count == CNT_AE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= '0;
            err_pulse  <= 1'b0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
        end else if (chk_en) begin
            if (|mis) begin
                err_sticky <= err_sticky | mis;
                err_pulse  <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + SAT_STEP;
                end
            end else begin
                err_pulse <= 1'b0;
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + SAT_STEP;
                end
            end
        end else begin
            err_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_sb_checker.sv
// Directed bench: a small well-behaved FIFO feeds the checker, with knobs that
// corrupt single observed outputs to provoke specific checker errors.
module tb_fifo_sb_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chk_en = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] din = '0;
    logic        kill_uf = 1'b0;
    logic        corrupt = 1'b0;
    logic        bad_ae = 1'b0;

    logic [7:0]  err_sticky;
    logic        err_pulse;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic [3:0]  model_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Observed FIFO: depth 8, registered data/ack/overflow/underflow.
    logic [15:0] f_mem [8];
    logic [3:0]  f_cnt;
    logic [2:0]  f_wp, f_rp;
    logic [15:0] f_dout;
    logic        f_ack, f_ov, f_uf;
    logic        f_w, f_r;

    assign f_w = wr_en && (f_cnt != 4'd8);
    assign f_r = rd_en && (f_cnt != 4'd0);

    always @(posedge clk) begin
        if (rst) begin
            f_cnt <= '0; f_wp <= '0; f_rp <= '0;
            f_dout <= '0; f_ack <= 1'b0; f_ov <= 1'b0; f_uf <= 1'b0;
        end else begin
            f_ack <= f_w;
            f_ov  <= wr_en && (f_cnt == 4'd8);
            f_uf  <= rd_en && (f_cnt == 4'd0);
            if (f_w) begin
                f_mem[f_wp] <= din;
                f_wp <= f_wp + 3'd1;
            end
            if (f_r) begin
                f_dout <= f_mem[f_rp];
                f_rp <= f_rp + 3'd1;
            end
            f_cnt <= f_cnt + {3'b000, f_w} - {3'b000, f_r};
        end
    end

    fifo_sb_checker_if #(.FIFO_WIDTH(16)) mif ();

    assign mif.mon_data_in     = din;
    assign mif.mon_wr_en       = wr_en;
    assign mif.mon_rd_en       = rd_en;
    assign mif.mon_data_out    = corrupt ? 16'hDEAD : f_dout;
    assign mif.mon_wr_ack      = f_ack;
    assign mif.mon_overflow    = f_ov;
    assign mif.mon_underflow   = f_uf & ~kill_uf;
    assign mif.mon_full        = (f_cnt == 4'd8);
    assign mif.mon_empty       = (f_cnt == 4'd0);
    assign mif.mon_almostfull  = (f_cnt == 4'd7);
    assign mif.mon_almostempty = (f_cnt == 4'd1) ^ bad_ae;

    fifo_sb_checker #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .mon(mif.slave),
        .err_sticky(err_sticky), .err_pulse(err_pulse),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .model_count(model_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset, then 10 clean idle cycles.
        tick(); tick();
        rst = 1'b0;
        chk("rst_pass",   32'(pass_cnt),    0);
        chk("rst_err",    32'(err_cnt),     0);
        chk("rst_sticky", 32'(err_sticky),  0);
        chk("rst_pulse",  32'(err_pulse),   0);
        chk("rst_count",  32'(model_count), 0);
        repeat (10) tick();
        chk("idle_pass",   32'(pass_cnt),    10);
        chk("idle_err",    32'(err_cnt),     0);
        chk("idle_sticky", 32'(err_sticky),  0);
        chk("idle_count",  32'(model_count), 0);

        // Fill with A000..A007, then drain in order.
        for (int i = 0; i < 8; i++) begin
            din = 16'hA000 + 16'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        chk("fill_count", 32'(model_count), 8);
        rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("drain_count", 32'(model_count), 32'(8 - k));
        end
        rd_en = 1'b0;
        tick();
        chk("drain_err",  32'(err_cnt),  0);
        chk("drain_pass", 32'(pass_cnt), 27);

        // Full FIFO with simultaneous write+read: read only, overflow expected.
        for (int i = 0; i < 8; i++) begin
            din = 16'hB000 + 16'(i);
            wr_en = 1'b1;
            tick();
        end
        din = 16'hBEEF;
        rd_en = 1'b1;
        tick();
        chk("fullboth_count", 32'(model_count), 7);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("fullboth_err",    32'(err_cnt),    0);
        chk("fullboth_pass",   32'(pass_cnt),   37);
        chk("fullboth_sticky", 32'(err_sticky), 0);
        rd_en = 1'b1;
        repeat (7) tick();
        rd_en = 1'b0;
        tick();
        chk("empty_again_count", 32'(model_count), 0);
        chk("empty_again_pass",  32'(pass_cnt),    45);

        // Read from empty while the observed underflow is stuck low.
        kill_uf = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        chk("uf_sticky", 32'(err_sticky), 32'h08);
        chk("uf_pulse",  32'(err_pulse),  1);
        chk("uf_err",    32'(err_cnt),    1);
        chk("uf_pass",   32'(pass_cnt),   46);
        tick();
        chk("uf_pulse_drop", 32'(err_pulse), 0);
        chk("uf_pass_next",  32'(pass_cnt),  47);
        kill_uf = 1'b0;

        // Corrupt the data returned for the A003 read.
        for (int i = 0; i < 4; i++) begin
            din = 16'hA000 + 16'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        repeat (4) tick();
        rd_en = 1'b0;
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        chk("data_sticky", 32'(err_sticky), 32'h09);
        chk("data_err",    32'(err_cnt),    2);
        chk("data_pulse",  32'(err_pulse),  1);
        repeat (3) tick();
        chk("data_pass_after", 32'(pass_cnt), 58);
        chk("data_err_after",  32'(err_cnt),  2);

        // Wrong almostempty flag for one cycle.
        bad_ae = 1'b1;
        tick();
        bad_ae = 1'b0;
        chk("ae_sticky", 32'(err_sticky), 32'h89);
        chk("ae_err",    32'(err_cnt),    3);

        // Checking disabled: a provoked underflow mismatch must not count.
        chk_en = 1'b0;
        kill_uf = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        chk("dis_pulse",  32'(err_pulse),  0);
        chk("dis_err",    32'(err_cnt),    3);
        chk("dis_pass",   32'(pass_cnt),   58);
        chk("dis_sticky", 32'(err_sticky), 32'h89);
        chk_en = 1'b1;
        kill_uf = 1'b0;

        // Interleaved traffic to wrap the pointers, then reset mid-stream.
        for (int i = 0; i < 20; i++) begin
            din = 16'hC000 + 16'(i);
            wr_en = 1'b1;
            rd_en = (i >= 2);
            tick();
        end
        chk("wrap_count", 32'(model_count), 2);
        chk("wrap_pass",  32'(pass_cnt),    78);
        chk("wrap_err",   32'(err_cnt),     3);
        rst = 1'b1;
        tick();
        chk("mid_rst_pass",   32'(pass_cnt),    0);
        chk("mid_rst_err",    32'(err_cnt),     0);
        chk("mid_rst_sticky", 32'(err_sticky),  0);
        chk("mid_rst_pulse",  32'(err_pulse),   0);
        chk("mid_rst_count",  32'(model_count), 0);
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("post_rst_pass",   32'(pass_cnt),    1);
        chk("post_rst_err",    32'(err_cnt),     0);
        chk("post_rst_count",  32'(model_count), 0);
        chk("post_rst_sticky", 32'(err_sticky),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
